// File: rtl/gpu_ctrl_regs_pkg.sv
// gpu_ctrl_pkg: shared constants and types for the GPU control block.
// Holds register offsets, CTRL/STATUS bit positions, reset values, AXI resp.
package gpu_ctrl_pkg;

    // Register byte offsets (bits [5:2] are decoded)
    localparam logic [5:0] OFF_CTRL        = 6'h00;
    localparam logic [5:0] OFF_STATUS      = 6'h04;
    localparam logic [5:0] OFF_BASE_INSTR  = 6'h08;
    localparam logic [5:0] OFF_BASE_DATA   = 6'h0C;
    localparam logic [5:0] OFF_NUM_BLOCKS  = 6'h10;
    localparam logic [5:0] OFF_WARPS       = 6'h14;
    localparam logic [5:0] OFF_DEBUG_ADDR  = 6'h18;
    localparam logic [5:0] OFF_DEBUG_DATA  = 6'h1C;
    localparam logic [5:0] OFF_CYCLE_COUNT = 6'h20;

    localparam int CTRL_START_BIT      = 0;
    localparam int CTRL_SOFT_RESET_BIT = 1;
    localparam int STATUS_BUSY_BIT     = 0;
    localparam int STATUS_DONE_BIT     = 1;

    localparam logic [31:0] RST_BASE_INSTR      = 32'd0;
    localparam logic [31:0] RST_BASE_DATA       = 32'd0;
    localparam logic [31:0] RST_NUM_BLOCKS      = 32'd1;
    localparam logic [31:0] RST_WARPS_PER_BLOCK = 32'd1;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    // Byte-lane merge of a write into an existing register value
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gpu_ctrl_regs_if.sv
// gpu_ctrl_regs_if: AXI4-Lite slave bus bundle for gpu_ctrl_regs.
// Ports: AW/W/B/AR/R channels; master = PS side, slave = register block.
interface gpu_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic [3:0]            s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arvalid,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/gpu_ctrl_regs_axil.sv
// gpu_ctrl_axil_if: AXI4-Lite handshake capture for the register file.
// Ports: clk/reset, s_axi slave; o_wr_* one-cycle write strobe; o_rd_*/i_rd_data read.
module gpu_ctrl_axil_if
    import gpu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    gpu_ctrl_regs_if.slave s_axi,
    output logic        o_wr_en,
    output logic [3:0]  o_wr_idx,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_strb,
    output logic        o_rd_en,
    output logic [3:0]  o_rd_idx,
    input  logic [31:0] i_rd_data
);

    logic        r_aw_held;
    logic [3:0]  r_aw_idx;
    logic        r_w_held;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;
    logic        r_bvalid;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic [ADDR_WIDTH-1:0] w_awaddr;
    logic [ADDR_WIDTH-1:0] w_araddr;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_unused;

    assign w_awaddr = s_axi.s_axi_awaddr;
    assign w_araddr = s_axi.s_axi_araddr;
    // Byte-lane bits of the address are not decoded
    assign w_unused = ^{w_awaddr[1:0], w_araddr[1:0]};

    assign s_axi.s_axi_awready = !r_aw_held && !r_bvalid;
    assign s_axi.s_axi_wready  = !r_w_held && !r_bvalid;
    assign s_axi.s_axi_arready = !r_rvalid;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_bresp   = RESP_OKAY;
    assign s_axi.s_axi_rvalid  = r_rvalid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = RESP_OKAY;

    assign w_aw_hs = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_w_hs  = s_axi.s_axi_wvalid && s_axi.s_axi_wready;
    assign w_ar_hs = s_axi.s_axi_arvalid && s_axi.s_axi_arready;

    // Write fires once both halves are held; held flags drop that edge
    assign o_wr_en   = r_aw_held && r_w_held;
    assign o_wr_idx  = r_aw_idx;
    assign o_wr_data = r_w_data;
    assign o_wr_strb = r_w_strb;

    assign o_rd_en  = w_ar_hs;
    assign o_rd_idx = w_araddr[5:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= w_awaddr[5:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi.s_axi_wdata;
                r_w_strb <= s_axi.s_axi_wstrb;
            end
            if (o_wr_en) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else if (r_bvalid && s_axi.s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= i_rd_data;
        end else if (r_rvalid && s_axi.s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/gpu_ctrl_regs.sv
// gpu_ctrl_regs: AXI4-Lite control/status registers driving the GPU core.
// Ports: clk, reset (async high), s_axi bus, launch config/start/soft_reset
// outputs, execution_done in, debug window. Optional cycle counter enabled
// by GPU_CTRL_CYCLE_COUNTER_EN.
module gpu_ctrl_regs
    import gpu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH       = 6,
    parameter int DATA_WIDTH       = 32,
    parameter int DEBUG_ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    gpu_ctrl_regs_if.slave              s_axi,
    output logic [DATA_WIDTH-1:0]       base_instr,
    output logic [DATA_WIDTH-1:0]       base_data,
    output logic [DATA_WIDTH-1:0]       num_blocks,
    output logic [DATA_WIDTH-1:0]       warps_per_block,
    output logic                        execution_start,
    output logic                        soft_reset,
    input  logic                        execution_done,
    output logic [DEBUG_ADDR_WIDTH-1:0] debug_reg_addr,
    input  logic [DATA_WIDTH-1:0]       debug_reg_data
);

    logic                        w_wr_en;
    logic [3:0]                  w_wr_idx;
    logic [DATA_WIDTH-1:0]       w_wr_data;
    logic [3:0]                  w_wr_strb;
    logic                        w_rd_en;
    logic [3:0]                  w_rd_idx;
    logic [DATA_WIDTH-1:0]       w_rd_data;
    logic [5:0]                  w_wr_off;
    logic [5:0]                  w_rd_off;
    logic                        w_start_acc;
    logic                        w_done_rise;
    logic [DATA_WIDTH-1:0]       w_cycle_cnt;

    logic [DATA_WIDTH-1:0]       r_base_instr;
    logic [DATA_WIDTH-1:0]       r_base_data;
    logic [DATA_WIDTH-1:0]       r_num_blocks;
    logic [DATA_WIDTH-1:0]       r_warps;
    logic [DEBUG_ADDR_WIDTH-1:0] r_debug_addr;
    logic                        r_soft_reset;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_done_q;
    logic                        r_exec_start;

    gpu_ctrl_axil_if #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_axil (
        .clk       (clk),
        .reset     (reset),
        .s_axi     (s_axi),
        .o_wr_en   (w_wr_en),
        .o_wr_idx  (w_wr_idx),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb),
        .o_rd_en   (w_rd_en),
        .o_rd_idx  (w_rd_idx),
        .i_rd_data (w_rd_data)
    );

    assign w_wr_off = {w_wr_idx, 2'b00};
    assign w_rd_off = {w_rd_idx, 2'b00};

    // START with SOFT_RESET in the same write is a reset request, not a launch
    assign w_start_acc = w_wr_en && (w_wr_off == OFF_CTRL) && w_wr_strb[0]
                      && w_wr_data[CTRL_START_BIT]
                      && !w_wr_data[CTRL_SOFT_RESET_BIT]
                      && !r_busy && !r_soft_reset;

    // Edge, not level: a done left high from an earlier run never completes
    assign w_done_rise = execution_done && !r_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base_instr <= RST_BASE_INSTR;
            r_base_data  <= RST_BASE_DATA;
            r_num_blocks <= RST_NUM_BLOCKS;
            r_warps      <= RST_WARPS_PER_BLOCK;
            r_debug_addr <= '0;
            r_soft_reset <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_q     <= 1'b0;
            r_exec_start <= 1'b0;
        end else begin
            r_exec_start <= w_start_acc;
            r_done_q     <= execution_done;
            if (w_wr_en) begin
                case (w_wr_off)
                    OFF_CTRL: begin
                        if (w_wr_strb[0])
                            r_soft_reset <= w_wr_data[CTRL_SOFT_RESET_BIT];
                    end
                    OFF_BASE_INSTR: begin
                        if (!r_busy)
                            r_base_instr <= apply_wstrb(r_base_instr, w_wr_data, w_wr_strb);
                    end
                    OFF_BASE_DATA: begin
                        if (!r_busy)
                            r_base_data <= apply_wstrb(r_base_data, w_wr_data, w_wr_strb);
                    end
                    OFF_NUM_BLOCKS: begin
                        if (!r_busy)
                            r_num_blocks <= apply_wstrb(r_num_blocks, w_wr_data, w_wr_strb);
                    end
                    OFF_WARPS: begin
                        if (!r_busy)
                            r_warps <= apply_wstrb(r_warps, w_wr_data, w_wr_strb);
                    end
                    OFF_DEBUG_ADDR: begin
                        if (w_wr_strb[0])
                            r_debug_addr <= w_wr_data[DEBUG_ADDR_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
            if (r_soft_reset) begin
                r_busy <= 1'b0;
                r_done <= 1'b0;
            end else if (w_start_acc) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (r_busy && w_done_rise) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

`ifdef GPU_CTRL_CYCLE_COUNTER_EN
    logic [DATA_WIDTH-1:0] r_cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (w_start_acc) begin
            r_cycle_cnt <= '0;
        end else if (r_busy && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign w_cycle_cnt = r_cycle_cnt;
`else
    assign w_cycle_cnt = '0;
`endif

    // Read mux samples current state, so STATUS shows the pre-change value
    always_comb begin
        w_rd_data = '0;
        if (w_rd_en) begin
            case (w_rd_off)
                OFF_CTRL:        w_rd_data[CTRL_SOFT_RESET_BIT] = r_soft_reset;
                OFF_STATUS: begin
                    w_rd_data[STATUS_BUSY_BIT] = r_busy;
                    w_rd_data[STATUS_DONE_BIT] = r_done;
                end
                OFF_BASE_INSTR:  w_rd_data = r_base_instr;
                OFF_BASE_DATA:   w_rd_data = r_base_data;
                OFF_NUM_BLOCKS:  w_rd_data = r_num_blocks;
                OFF_WARPS:       w_rd_data = r_warps;
                OFF_DEBUG_ADDR:  w_rd_data[DEBUG_ADDR_WIDTH-1:0] = r_debug_addr;
                OFF_DEBUG_DATA:  w_rd_data = debug_reg_data;
                OFF_CYCLE_COUNT: w_rd_data = w_cycle_cnt;
                default:         w_rd_data = '0;
            endcase
        end
    end

    assign base_instr      = r_base_instr;
    assign base_data       = r_base_data;
    assign num_blocks      = r_num_blocks;
    assign warps_per_block = r_warps;
    assign execution_start = r_exec_start;
    assign soft_reset      = r_soft_reset;
    assign debug_reg_addr  = r_debug_addr;

endmodule
